// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, queue entry, default reset PC.
package fetch_pkg;

  typedef enum logic {FETCH, DROP} fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_entry_t;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory req/ack bus; fetch_unit is the master, memory the slave.
interface fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input  ack, rdata);
  modport slave  (input  req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetched words; flush wins over push/pop in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int QDEPTH = 2,
  localparam int AW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int CW     = AW + 1
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t  mem [QDEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(QDEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, fetches over imem, queues words, drives the IF/ID slot.
// Optional FETCH_PERF_EN adds saturating stall-cycle and redirect counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int          QDEPTH   = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  fetch_if.master     imem,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  localparam int              AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int              CW = AW + 1;
  localparam logic [CW-1:0]   QD = CW'(QDEPTH);

  fetch_state_e  state, state_nxt;
  logic [31:0]   pc, drop_addr;
  logic          push, pop;
  fetch_entry_t  q_wdata, q_rdata;
  logic [CW-1:0] q_count;
  logic          q_empty, q_full;

  assign q_wdata = '{instr: imem.rdata, pc4: pc + 32'd4};
  assign pop     = !stall && !redirect && !q_empty;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  always_comb begin
    state_nxt = state;
    imem.req  = 1'b0;
    imem.addr = pc;
    push      = 1'b0;
    case (state)
      FETCH: begin
        // The held request is the only outstanding one, so queue occupancy gates it.
        imem.req = (q_count < QD);
        push     = imem.req && imem.ack && !redirect && !q_full;
        if (redirect && imem.req && !imem.ack) state_nxt = DROP;
      end
      DROP: begin
        imem.req  = 1'b1;
        imem.addr = drop_addr;
        if (imem.ack) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drop_addr  <= '0;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc4   <= '0;
    end else begin
      state <= state_nxt;
      if (redirect)  pc <= redirect_pc & ~32'd3;
      else if (push) pc <= pc + 32'd4;
      // Tracks pc while fetching so the stale address survives the redirect into DROP.
      if (state == FETCH) drop_addr <= pc;
      if (redirect) begin
        ifid_valid <= 1'b0;
      end else if (!stall) begin
        ifid_valid <= !q_empty;
        if (!q_empty) begin
          ifid_instr <= q_rdata.instr;
          ifid_pc4   <= q_rdata.pc4;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && perf_stall_cnt != 16'hFFFF)    perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (redirect && perf_flush_cnt != 16'hFFFF) perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule
